// File: rtl/mem_arbiter_pkg.sv
// Shared types for the instruction/data memory arbiter.
package mem_arbiter_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE    = 2'd0,
    ARB_ACCESS  = 2'd1,
    ARB_RD_WAIT = 2'd2
  } arb_state_t;

  typedef enum logic {
    OWN_CPU = 1'b0,
    OWN_LDR = 1'b1
  } owner_t;

endpackage

// File: rtl/mem_arbiter_if.sv
// Bundle of the CPU, loader and memory-side signals around the arbiter.
interface mem_arbiter_if #(
  parameter int AWIDTH = 5,
  parameter int DWIDTH = 8
);
  logic              cpu_req;
  logic              cpu_we;
  logic [AWIDTH-1:0] cpu_addr;
  logic [DWIDTH-1:0] cpu_wdata;
  logic              cpu_gnt;
  logic [DWIDTH-1:0] cpu_rdata;
  logic              cpu_rvalid;

  logic              ldr_req;
  logic              ldr_we;
  logic [AWIDTH-1:0] ldr_addr;
  logic [DWIDTH-1:0] ldr_wdata;
  logic              ldr_gnt;
  logic [DWIDTH-1:0] ldr_rdata;
  logic              ldr_rvalid;

  logic [AWIDTH-1:0] mem_addr;
  logic [DWIDTH-1:0] mem_wdata;
  logic              mem_rd;
  logic              mem_wr;
  logic [DWIDTH-1:0] mem_rdata;
  logic              busy;

  // Requesters and memory model side
  modport master (
    output cpu_req, cpu_we, cpu_addr, cpu_wdata,
    output ldr_req, ldr_we, ldr_addr, ldr_wdata,
    output mem_rdata,
    input  cpu_gnt, cpu_rdata, cpu_rvalid,
    input  ldr_gnt, ldr_rdata, ldr_rvalid,
    input  mem_addr, mem_wdata, mem_rd, mem_wr, busy
  );

  // Arbiter side
  modport slave (
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
    input  ldr_req, ldr_we, ldr_addr, ldr_wdata,
    input  mem_rdata,
    output cpu_gnt, cpu_rdata, cpu_rvalid,
    output ldr_gnt, ldr_rdata, ldr_rvalid,
    output mem_addr, mem_wdata, mem_rd, mem_wr, busy
  );
endinterface

// File: rtl/mem_arbiter_chk.sv
// Protocol checks on the arbiter's registered outputs.
module mem_arbiter_chk (
  input logic clk,
  input logic rst,
  input logic i_cpu_gnt,
  input logic i_ldr_gnt,
  input logic i_mem_rd,
  input logic i_mem_wr
);

  a_strobe_excl: assert property (@(posedge clk) disable iff (rst) !(i_mem_rd && i_mem_wr));
  a_gnt_onehot:  assert property (@(posedge clk) disable iff (rst) !(i_cpu_gnt && i_ldr_gnt));

endmodule

// File: rtl/mem_arbiter_rr2.sv
// Two-requester round-robin picker; on a tie the side that did not win last goes.
module arb_rr2
  import mem_arbiter_pkg::*;
(
  input  logic [1:0] i_req,
  input  owner_t     i_rr_last,
  output owner_t     o_winner,
  output logic       o_valid
);

  // Bit 0 is the CPU, bit 1 is the loader
  always_comb begin
    o_winner = OWN_CPU;
    o_valid  = 1'b0;
    case (i_req)
      2'b01: begin
        o_winner = OWN_CPU;
        o_valid  = 1'b1;
      end
      2'b10: begin
        o_winner = OWN_LDR;
        o_valid  = 1'b1;
      end
      2'b11: begin
        o_winner = (i_rr_last == OWN_CPU) ? OWN_LDR : OWN_CPU;
        o_valid  = 1'b1;
      end
      default: begin
        o_winner = OWN_CPU;
        o_valid  = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/mem_arbiter.sv
// Single-port memory arbiter between the CPU sequencer and the loader/debug port.
// One access at a time; grants, strobes and read returns are all registered.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int AWIDTH = 5,
  parameter int DWIDTH = 8,
  parameter int RD_LAT = 1
) (
  input logic          clk,
  input logic          rst,
  mem_arbiter_if.slave bus
);

  localparam int              CW       = $clog2(RD_LAT + 1);
  localparam logic [CW-1:0]   CNT_LOAD = CW'(RD_LAT - 1);

  if (RD_LAT < 1) begin : g_rd_lat_chk
    $error("mem_arbiter: RD_LAT must be at least 1");
  end

  arb_state_t        r_state;
  owner_t            r_owner;
  owner_t            r_rr_last;
  logic              r_we;
  logic [CW-1:0]     r_cnt;
  logic              r_busy;
  logic              r_cpu_gnt;
  logic              r_ldr_gnt;
  logic [AWIDTH-1:0] r_mem_addr;
  logic [DWIDTH-1:0] r_mem_wdata;
  logic              r_mem_rd;
  logic              r_mem_wr;
  logic [DWIDTH-1:0] r_cpu_rdata;
  logic              r_cpu_rvalid;
  logic [DWIDTH-1:0] r_ldr_rdata;
  logic              r_ldr_rvalid;

  owner_t            w_winner;
  logic              w_valid;
  logic [AWIDTH-1:0] w_sel_addr;
  logic [DWIDTH-1:0] w_sel_wdata;
  logic              w_sel_we;
  logic              w_capture;

  arb_rr2 u_rr2 (
    .i_req     ({bus.ldr_req, bus.cpu_req}),
    .i_rr_last (r_rr_last),
    .o_winner  (w_winner),
    .o_valid   (w_valid)
  );

  // Winner's request fields and the read-data capture point
  always_comb begin
    w_sel_addr  = (w_winner == OWN_CPU) ? bus.cpu_addr  : bus.ldr_addr;
    w_sel_wdata = (w_winner == OWN_CPU) ? bus.cpu_wdata : bus.ldr_wdata;
    w_sel_we    = (w_winner == OWN_CPU) ? bus.cpu_we    : bus.ldr_we;
    w_capture   = ((r_state == ARB_ACCESS) && !r_we && (RD_LAT == 1)) ||
                  ((r_state == ARB_RD_WAIT) && (r_cnt == CW'(1)));
  end

  // Arbitration FSM with registered grants and memory strobes
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= ARB_IDLE;
      r_owner     <= OWN_CPU;
      r_rr_last   <= OWN_LDR;
      r_we        <= 1'b0;
      r_cnt       <= {CW{1'b0}};
      r_busy      <= 1'b0;
      r_cpu_gnt   <= 1'b0;
      r_ldr_gnt   <= 1'b0;
      r_mem_addr  <= {AWIDTH{1'b0}};
      r_mem_wdata <= {DWIDTH{1'b0}};
      r_mem_rd    <= 1'b0;
      r_mem_wr    <= 1'b0;
    end else begin
      r_cpu_gnt <= 1'b0;
      r_ldr_gnt <= 1'b0;
      case (r_state)
        ARB_IDLE: begin
          if (w_valid) begin
            r_state     <= ARB_ACCESS;
            r_owner     <= w_winner;
            r_rr_last   <= w_winner;
            r_we        <= w_sel_we;
            r_busy      <= 1'b1;
            r_mem_addr  <= w_sel_addr;
            r_mem_wdata <= w_sel_wdata;
            r_mem_wr    <= w_sel_we;
            r_mem_rd    <= !w_sel_we;
            r_cpu_gnt   <= (w_winner == OWN_CPU);
            r_ldr_gnt   <= (w_winner == OWN_LDR);
          end else begin
            r_busy   <= 1'b0;
            r_mem_rd <= 1'b0;
            r_mem_wr <= 1'b0;
          end
        end
        ARB_ACCESS: begin
          if (r_we || (RD_LAT == 1)) begin
            r_state  <= ARB_IDLE;
            r_busy   <= 1'b0;
            r_mem_wr <= 1'b0;
            r_mem_rd <= 1'b0;
          end else begin
            r_state <= ARB_RD_WAIT;
            r_cnt   <= CNT_LOAD;
          end
        end
        ARB_RD_WAIT: begin
          if (r_cnt == CW'(1)) begin
            r_state  <= ARB_IDLE;
            r_busy   <= 1'b0;
            r_mem_rd <= 1'b0;
          end else begin
            r_cnt <= r_cnt - CW'(1);
          end
        end
        default: begin
          r_state  <= ARB_IDLE;
          r_busy   <= 1'b0;
          r_mem_rd <= 1'b0;
          r_mem_wr <= 1'b0;
        end
      endcase
    end
  end

  // Read-data return to the owner only; the other side keeps its last value
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cpu_rdata  <= {DWIDTH{1'b0}};
      r_cpu_rvalid <= 1'b0;
      r_ldr_rdata  <= {DWIDTH{1'b0}};
      r_ldr_rvalid <= 1'b0;
    end else begin
      r_cpu_rvalid <= 1'b0;
      r_ldr_rvalid <= 1'b0;
      if (w_capture && (r_owner == OWN_CPU)) begin
        r_cpu_rdata  <= bus.mem_rdata;
        r_cpu_rvalid <= 1'b1;
      end else if (w_capture) begin
        r_ldr_rdata  <= bus.mem_rdata;
        r_ldr_rvalid <= 1'b1;
      end else begin
        r_cpu_rdata <= r_cpu_rdata;
        r_ldr_rdata <= r_ldr_rdata;
      end
    end
  end

  assign bus.cpu_gnt    = r_cpu_gnt;
  assign bus.cpu_rdata  = r_cpu_rdata;
  assign bus.cpu_rvalid = r_cpu_rvalid;
  assign bus.ldr_gnt    = r_ldr_gnt;
  assign bus.ldr_rdata  = r_ldr_rdata;
  assign bus.ldr_rvalid = r_ldr_rvalid;
  assign bus.mem_addr   = r_mem_addr;
  assign bus.mem_wdata  = r_mem_wdata;
  assign bus.mem_rd     = r_mem_rd;
  assign bus.mem_wr     = r_mem_wr;
  assign bus.busy       = r_busy;

  mem_arbiter_chk u_chk (
    .clk       (clk),
    .rst       (rst),
    .i_cpu_gnt (r_cpu_gnt),
    .i_ldr_gnt (r_ldr_gnt),
    .i_mem_rd  (r_mem_rd),
    .i_mem_wr  (r_mem_wr)
  );

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: an RD_LAT=2 build and an RD_LAT=1 build.
module tb_mem_arbiter;

  logic clk;
  logic rst;
  int   total;
  int   bad;

  logic [7:0] mem [0:31];
  logic [1:0] rd_cnt2;

  mem_arbiter_if #(.AWIDTH(5), .DWIDTH(8)) if2 ();
  mem_arbiter_if #(.AWIDTH(5), .DWIDTH(8)) if1 ();

  mem_arbiter #(.AWIDTH(5), .DWIDTH(8), .RD_LAT(2)) u_dut2 (.clk(clk), .rst(rst), .bus(if2));
  mem_arbiter #(.AWIDTH(5), .DWIDTH(8), .RD_LAT(1)) u_dut1 (.clk(clk), .rst(rst), .bus(if1));

  always #5 clk = ~clk;

  // Memory model: data only appears in the last cycle of the read strobe
  always_ff @(posedge clk or posedge rst) begin
    if (rst) rd_cnt2 <= 2'd0;
    else if (if2.mem_rd) rd_cnt2 <= rd_cnt2 + 2'd1;
    else rd_cnt2 <= 2'd0;
  end
  assign if2.mem_rdata = (if2.mem_rd && rd_cnt2 == 2'd1) ? mem[if2.mem_addr] : 8'hEE;
  assign if1.mem_rdata = if1.mem_rd ? mem[if1.mem_addr] : 8'hEE;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic chk5(input string tag, input logic [4:0] obs, input logic [4:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk8(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  initial begin
    total = 0;
    bad   = 0;
    clk   = 1'b0;
    rst   = 1'b1;
    for (int i = 0; i < 32; i++) mem[i] = 8'(i) ^ 8'h55;
    mem[5'h0A] = 8'h3C;
    mem[5'h03] = 8'h96;
    mem[5'h07] = 8'hC3;
    {if2.cpu_req, if2.cpu_we, if2.ldr_req, if2.ldr_we} = 4'b0000;
    {if2.cpu_addr, if2.ldr_addr, if2.cpu_wdata, if2.ldr_wdata} = 26'd0;
    {if1.cpu_req, if1.cpu_we, if1.ldr_req, if1.ldr_we} = 4'b0000;
    {if1.cpu_addr, if1.ldr_addr, if1.cpu_wdata, if1.ldr_wdata} = 26'd0;

    // Reset values
    step();
    chk1("rst_busy", if2.busy, 1'b0);
    chk1("rst_cpu_gnt", if2.cpu_gnt, 1'b0);
    chk1("rst_mem_rd", if2.mem_rd, 1'b0);
    chk1("rst_mem_wr", if2.mem_wr, 1'b0);
    chk5("rst_mem_addr", if2.mem_addr, 5'h00);
    chk8("rst_mem_wdata", if2.mem_wdata, 8'h00);
    chk8("rst_cpu_rdata", if2.cpu_rdata, 8'h00);
    chk1("rst1_busy", if1.busy, 1'b0);
    rst = 1'b0;

    // Read started, then aborted by reset in its grant cycle
    if2.cpu_req = 1'b1; if2.cpu_we = 1'b0; if2.cpu_addr = 5'h0A;
    step();
    chk1("abort_pre_gnt", if2.cpu_gnt, 1'b1);
    chk1("abort_pre_rd", if2.mem_rd, 1'b1);
    if2.cpu_req = 1'b0;
    rst = 1'b1;
    #1;
    chk1("abort_async_gnt", if2.cpu_gnt, 1'b0);
    chk1("abort_async_rd", if2.mem_rd, 1'b0);
    chk1("abort_async_busy", if2.busy, 1'b0);
    chk5("abort_async_addr", if2.mem_addr, 5'h00);
    step();
    chk1("abort_no_rvalid", if2.cpu_rvalid, 1'b0);
    rst = 1'b0;
    step();
    chk1("abort_idle_rvalid", if2.cpu_rvalid, 1'b0);
    chk1("abort_idle_busy", if2.busy, 1'b0);

    // Clean CPU read of 0A, RD_LAT=2
    if2.cpu_req = 1'b1; if2.cpu_we = 1'b0; if2.cpu_addr = 5'h0A;
    step();
    chk1("rd_c1_gnt", if2.cpu_gnt, 1'b1);
    chk1("rd_c1_ldr_gnt", if2.ldr_gnt, 1'b0);
    chk1("rd_c1_mem_rd", if2.mem_rd, 1'b1);
    chk5("rd_c1_addr", if2.mem_addr, 5'h0A);
    chk1("rd_c1_busy", if2.busy, 1'b1);
    if2.cpu_req = 1'b0;
    step();
    chk1("rd_c2_gnt", if2.cpu_gnt, 1'b0);
    chk1("rd_c2_mem_rd", if2.mem_rd, 1'b1);
    chk5("rd_c2_addr", if2.mem_addr, 5'h0A);
    chk1("rd_c2_rvalid", if2.cpu_rvalid, 1'b0);
    step();
    chk1("rd_c3_mem_rd", if2.mem_rd, 1'b0);
    chk1("rd_c3_rvalid", if2.cpu_rvalid, 1'b1);
    chk8("rd_c3_rdata", if2.cpu_rdata, 8'h3C);
    chk1("rd_c3_busy", if2.busy, 1'b0);
    chk1("rd_c3_ldr_rvalid", if2.ldr_rvalid, 1'b0);
    step();
    chk1("rd_c4_rvalid", if2.cpu_rvalid, 1'b0);

    // CPU write 1F <- A5
    if2.cpu_req = 1'b1; if2.cpu_we = 1'b1; if2.cpu_addr = 5'h1F; if2.cpu_wdata = 8'hA5;
    step();
    chk1("wr_gnt", if2.cpu_gnt, 1'b1);
    chk1("wr_mem_wr", if2.mem_wr, 1'b1);
    chk1("wr_mem_rd", if2.mem_rd, 1'b0);
    chk5("wr_addr", if2.mem_addr, 5'h1F);
    chk8("wr_wdata", if2.mem_wdata, 8'hA5);
    if2.cpu_req = 1'b0;
    step();
    chk1("wr_after_mem_wr", if2.mem_wr, 1'b0);
    chk1("wr_after_busy", if2.busy, 1'b0);
    chk1("wr_after_gnt", if2.cpu_gnt, 1'b0);
    chk8("wr_keep_rdata", if2.cpu_rdata, 8'h3C);

    // Both requesting out of reset, held for six write accesses
    rst = 1'b1;
    if2.cpu_req = 1'b1; if2.cpu_we = 1'b1; if2.cpu_addr = 5'h01; if2.cpu_wdata = 8'h11;
    if2.ldr_req = 1'b1; if2.ldr_we = 1'b1; if2.ldr_addr = 5'h02; if2.ldr_wdata = 8'h22;
    step();
    rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      step();
      chk1("alt_cpu_gnt", if2.cpu_gnt, (i % 2 == 0) ? 1'b1 : 1'b0);
      chk1("alt_ldr_gnt", if2.ldr_gnt, (i % 2 == 1) ? 1'b1 : 1'b0);
      chk5("alt_addr", if2.mem_addr, (i % 2 == 0) ? 5'h01 : 5'h02);
      chk1("alt_mem_wr", if2.mem_wr, 1'b1);
      step();
      chk1("alt_idle_gnt", if2.cpu_gnt | if2.ldr_gnt, 1'b0);
      chk1("alt_idle_busy", if2.busy, 1'b0);
    end
    if2.cpu_req = 1'b0;
    if2.ldr_req = 1'b0;
    step();
    chk1("alt_drained_busy", if2.busy, 1'b0);

    // Loader read of 03; CPU write request arrives during the wait cycle
    if2.ldr_req = 1'b1; if2.ldr_we = 1'b0; if2.ldr_addr = 5'h03;
    step();
    chk1("lrd_c1_ldr_gnt", if2.ldr_gnt, 1'b1);
    chk1("lrd_c1_cpu_gnt", if2.cpu_gnt, 1'b0);
    chk1("lrd_c1_mem_rd", if2.mem_rd, 1'b1);
    chk5("lrd_c1_addr", if2.mem_addr, 5'h03);
    if2.ldr_req = 1'b0;
    step();
    chk1("lrd_c2_mem_rd", if2.mem_rd, 1'b1);
    if2.cpu_req = 1'b1; if2.cpu_we = 1'b1; if2.cpu_addr = 5'h11; if2.cpu_wdata = 8'h5A;
    step();
    chk1("lrd_c3_ldr_rvalid", if2.ldr_rvalid, 1'b1);
    chk8("lrd_c3_ldr_rdata", if2.ldr_rdata, 8'h96);
    chk1("lrd_c3_cpu_gnt", if2.cpu_gnt, 1'b0);
    chk1("lrd_c3_cpu_rvalid", if2.cpu_rvalid, 1'b0);
    chk8("lrd_c3_cpu_rdata", if2.cpu_rdata, 8'h00);
    chk1("lrd_c3_busy", if2.busy, 1'b0);
    step();
    chk1("lrd_c4_cpu_gnt", if2.cpu_gnt, 1'b1);
    chk1("lrd_c4_mem_wr", if2.mem_wr, 1'b1);
    chk5("lrd_c4_addr", if2.mem_addr, 5'h11);
    chk1("lrd_c4_ldr_rvalid", if2.ldr_rvalid, 1'b0);
    if2.cpu_req = 1'b0;
    step();
    chk1("lrd_c5_busy", if2.busy, 1'b0);

    // CPU request pulses for one cycle while the loader owns the bus
    if2.ldr_req = 1'b1; if2.ldr_we = 1'b0; if2.ldr_addr = 5'h03;
    step();
    chk1("abn_ldr_gnt", if2.ldr_gnt, 1'b1);
    if2.ldr_req = 1'b0;
    if2.cpu_req = 1'b1; if2.cpu_we = 1'b1; if2.cpu_addr = 5'h12;
    step();
    if2.cpu_req = 1'b0;
    step();
    chk1("abn_ldr_rvalid", if2.ldr_rvalid, 1'b1);
    for (int i = 0; i < 3; i++) begin
      step();
      chk1("abn_cpu_gnt", if2.cpu_gnt, 1'b0);
      chk1("abn_mem_wr", if2.mem_wr, 1'b0);
      chk1("abn_mem_rd", if2.mem_rd, 1'b0);
      chk1("abn_busy", if2.busy, 1'b0);
    end

    // RD_LAT=1 build: CPU read of 07
    if1.cpu_req = 1'b1; if1.cpu_we = 1'b0; if1.cpu_addr = 5'h07;
    step();
    chk1("l1_c1_gnt", if1.cpu_gnt, 1'b1);
    chk1("l1_c1_mem_rd", if1.mem_rd, 1'b1);
    chk5("l1_c1_addr", if1.mem_addr, 5'h07);
    chk1("l1_c1_busy", if1.busy, 1'b1);
    if1.cpu_req = 1'b0;
    step();
    chk1("l1_c2_mem_rd", if1.mem_rd, 1'b0);
    chk1("l1_c2_rvalid", if1.cpu_rvalid, 1'b1);
    chk8("l1_c2_rdata", if1.cpu_rdata, 8'hC3);
    chk1("l1_c2_busy", if1.busy, 1'b0);
    chk1("l1_c2_ldr_rvalid", if1.ldr_rvalid, 1'b0);
    step();
    chk1("l1_c3_rvalid", if1.cpu_rvalid, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
